multibank_buffer: RTL and testbench
===================================

Name: multibank_buffer

Overview:
Parametrised successor to the ping-pong capture buffer. Stores sampled words into BANK_COUNT equal banks in a single clock domain. Whole banks are handed to the USB-side reader in write order: the reader always receives exactly BANK_DEPTH words per burst, matching the FX3 end-point size. It sits between the ADC sample path and the USB data bus. It adds selectable overflow policy, gated writes, a registered read port, and overflow statistics.

Parameters:
DATA_WIDTH, 16, sample word width in bits
BANK_DEPTH, 8192, words per bank; power of 2, at least 4
BANK_COUNT, 4, number of banks; power of 2, at least 2
HOLD_CYCLES, 1000, cycles that bufferOverflow stays high after an overflow event; at least 1
OVERFLOW_MODE, 0, 0 = discard newest (overwrite the current write bank); 1 = discard the oldest complete bank where allowed

Ports:
clock  in  1  sole clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
dataIn  in  DATA_WIDTH  sample word
dataInValid  in  1  write dataIn this cycle
isReading  in  1  reader requests one word this cycle
dataOut  out  DATA_WIDTH  registered read data
dataOutValid  out  1  dataOut carries the word requested on the previous cycle
dataAvailable  out  1  at least one complete bank is awaiting read
bufferOverflow  out  1  overflow indicator, held high for HOLD_CYCLES
banksFull  out  clog2(BANK_COUNT)+1  count of complete, unread banks
overflowCount  out  16  overflow events, saturating at 16'hFFFF

Behaviour:
- Reset (asynchronous, active-high): every output is 0, and wrBank, wrAddr, rdBank, rdAddr and the hold counter are 0. Memory contents are not reset.
- Memory is BANK_COUNT*BANK_DEPTH words, addressed as {bank, addr}. Inferred as RAM with synchronous read.
- Write:
  - When dataInValid=1, store dataIn at {wrBank, wrAddr} and increment wrAddr.
  - A write with wrAddr == BANK_DEPTH-1 completes the bank and resets wrAddr to 0.
- Bank completion when no overflow occurs: wrBank advances (mod BANK_COUNT) and banksFull increments.
- Overflow condition: a bank completes while banksFull == BANK_COUNT-1 and no read-completion happens in the same cycle. Resolution depends on mode:
  - Mode 0: wrBank, rdBank and banksFull are unchanged. The just-written bank is rewritten from addr 0.
  - Mode 1 with rdAddr == 0 (no read in progress): rdBank advances, wrBank advances, banksFull is unchanged. The oldest bank is lost.
  - Mode 1 with rdAddr != 0: falls back to mode-0 behaviour, so a burst in progress is never corrupted.
- Every overflow event:
  - bufferOverflow goes to 1 on the next edge and the hold counter loads HOLD_CYCLES.
  - The counter decrements each cycle, and bufferOverflow clears when it reaches 0.
  - A new event during the hold reloads the counter.
  - overflowCount increments, saturating at 16'hFFFF.
- dataAvailable = (banksFull != 0). It is driven from registers with no combinational path from inputs.
- Read:
  - isReading is honoured only while dataAvailable=1. It reads {rdBank, rdAddr}; dataOut and dataOutValid=1 appear on the next edge (1-cycle latency).
  - rdAddr increments on each honoured read. The read at rdAddr == BANK_DEPTH-1 resets rdAddr to 0, advances rdBank and decrements banksFull.
  - isReading while dataAvailable=0 is ignored, and dataOutValid=0 on the next cycle.
  - dataOut holds its last value whenever dataOutValid=0.
- Simultaneous events:
  - Bank completion and read-completion in the same cycle: banksFull is unchanged, and it is not an overflow.
  - A write to the bank being read is impossible by construction, because wrBank is never a full bank.
- Reset mid-operation discards all banks. After reset the first data appears only after a fresh BANK_DEPTH words have been written.

Test Plan:
- DEPTH=4, COUNT=4: write 0..3 continuously -> after the 4th write, banksFull=1 and dataAvailable=1. Hold isReading 4 cycles -> dataOut 0,1,2,3 each one cycle after its request, then dataAvailable=0.
- Toggle dataInValid every other cycle while writing 8 words -> 2 banks complete. Read order is exact, and no gaps are introduced in the stored data.
- Mode 0, HOLD=8, no reads, write 16 words -> banksFull=3 after word 12. Word 16 overflows: bufferOverflow high for exactly 8 cycles, overflowCount=1. Reading 12 words returns 0..11.
- Mode 1, same stimulus -> banksFull=3. Reading 12 words returns 4..15; the bank holding 0..3 is dropped.
- Mode 1, one read accepted so rdAddr=1, then trigger overflow -> falls back to mode 0. The burst continues 1,2,3 uncorrupted.
- Bank completion on the same edge as the final read of a bank, with banksFull=3 -> no overflow, banksFull stays 3. Separately, assert reset mid-burst -> all outputs 0 asynchronously, with no spurious dataOutValid afterwards.

Source files
------------

// File: rtl/multibank_buffer.sv
// Multi-bank capture buffer: ADC words fill BANK_COUNT banks in order and whole banks are
// drained by the USB-side reader. Overflow policy is fixed by OVERFLOW_MODE.
module multibank_buffer #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned BANK_DEPTH    = 8192,
   parameter int unsigned BANK_COUNT    = 4,
   parameter int unsigned HOLD_CYCLES   = 1000,
   parameter int unsigned OVERFLOW_MODE = 0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DATA_WIDTH-1:0]         dataIn,
   input  logic                          dataInValid,
   input  logic                          isReading,
   output logic [DATA_WIDTH-1:0]         dataOut,
   output logic                          dataOutValid,
   output logic                          dataAvailable,
   output logic                          bufferOverflow,
   output logic [$clog2(BANK_COUNT):0]   banksFull,
   output logic [15:0]                   overflowCount
);

   localparam int unsigned AW = $clog2(BANK_DEPTH);
   localparam int unsigned BW = $clog2(BANK_COUNT);
   localparam int unsigned CW = BW + 1;
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned PW = AW + BW;

   logic [DATA_WIDTH-1:0] mem_q [BANK_COUNT*BANK_DEPTH];

   logic [AW-1:0]         wr_addr_q, wr_addr_d;
   logic [AW-1:0]         rd_addr_q, rd_addr_d;
   logic [BW-1:0]         wr_bank_q, wr_bank_d;
   logic [BW-1:0]         rd_bank_q, rd_bank_d;
   logic [CW-1:0]         banks_full_q, banks_full_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic [15:0]           ovf_cnt_q, ovf_cnt_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  data_out_valid_q, data_out_valid_d;

   logic          rd_en;
   logic          wr_last;
   logic          rd_last;
   logic          overflow;
   logic          drop_oldest;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign wr_ptr = {wr_bank_q, wr_addr_q};
   assign rd_ptr = {rd_bank_q, rd_addr_q};

   always_comb begin
      rd_en    = isReading && (banks_full_q != '0);
      wr_last  = dataInValid && (wr_addr_q == AW'(BANK_DEPTH - 1));
      rd_last  = rd_en && (rd_addr_q == AW'(BANK_DEPTH - 1));
      overflow = wr_last && !rd_last && (banks_full_q == CW'(BANK_COUNT - 1));
      // Dropping the oldest bank is only safe when no burst has started on it, including one
      // starting this very cycle.
      drop_oldest = overflow && (OVERFLOW_MODE == 1) && (rd_addr_q == '0) && !rd_en;

      wr_addr_d = wr_addr_q;
      if (dataInValid) begin
         wr_addr_d = wr_addr_q + AW'(1);
      end
      rd_addr_d = rd_addr_q;
      if (rd_en) begin
         rd_addr_d = rd_addr_q + AW'(1);
      end

      wr_bank_d = wr_bank_q;
      if (wr_last && (!overflow || drop_oldest)) begin
         wr_bank_d = wr_bank_q + BW'(1);
      end
      rd_bank_d = rd_bank_q;
      if (rd_last || drop_oldest) begin
         rd_bank_d = rd_bank_q + BW'(1);
      end

      banks_full_d = banks_full_q;
      unique case ({wr_last && !overflow, rd_last})
         2'b10:   banks_full_d = banks_full_q + CW'(1);
         2'b01:   banks_full_d = banks_full_q - CW'(1);
         default: banks_full_d = banks_full_q;
      endcase

      hold_d = hold_q;
      if (overflow) begin
         hold_d = HW'(HOLD_CYCLES);
      end else if (hold_q != '0) begin
         hold_d = hold_q - HW'(1);
      end

      ovf_cnt_d = ovf_cnt_q;
      if (overflow && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_d = ovf_cnt_q + 16'd1;
      end

      data_out_valid_d = rd_en;
      data_out_d       = data_out_q;
      if (rd_en) begin
         data_out_d = mem_q[rd_ptr];
      end
   end

   always_ff @(posedge clock) begin
      if (dataInValid) begin
         mem_q[wr_ptr] <= dataIn;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_addr_q        <= '0;
         rd_addr_q        <= '0;
         wr_bank_q        <= '0;
         rd_bank_q        <= '0;
         banks_full_q     <= '0;
         hold_q           <= '0;
         ovf_cnt_q        <= '0;
         data_out_q       <= '0;
         data_out_valid_q <= 1'b0;
      end else begin
         wr_addr_q        <= wr_addr_d;
         rd_addr_q        <= rd_addr_d;
         wr_bank_q        <= wr_bank_d;
         rd_bank_q        <= rd_bank_d;
         banks_full_q     <= banks_full_d;
         hold_q           <= hold_d;
         ovf_cnt_q        <= ovf_cnt_d;
         data_out_q       <= data_out_d;
         data_out_valid_q <= data_out_valid_d;
      end
   end

   assign dataOut        = data_out_q;
   assign dataOutValid   = data_out_valid_q;
   assign dataAvailable  = (banks_full_q != '0);
   assign bufferOverflow = (hold_q != '0);
   assign banksFull      = banks_full_q;
   assign overflowCount  = ovf_cnt_q;

endmodule

// File: tb/tb_multibank_buffer.sv
// Bench for multibank_buffer: a discard-newest and a discard-oldest instance share stimulus;
// each has its own queue of expected read words.
module tb_multibank_buffer;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned COUNT = 4;
   localparam int unsigned HOLD  = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic          is_reading = 1'b0;

   logic [DW-1:0] data_out0, data_out1;
   logic          data_out_valid0, data_out_valid1;
   logic          data_available0, data_available1;
   logic          buffer_overflow0, buffer_overflow1;
   logic [2:0]    banks_full0, banks_full1;
   logic [15:0]   overflow_count0, overflow_count1;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q0[$];
   int exp_q1[$];

   always #5 clock = ~clock;

   multibank_buffer #(
      .DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .BANK_COUNT(COUNT), .HOLD_CYCLES(HOLD),
      .OVERFLOW_MODE(0)
   ) u_dut0 (
      .clock(clock), .reset(reset), .dataIn(data_in), .dataInValid(data_in_valid),
      .isReading(is_reading), .dataOut(data_out0), .dataOutValid(data_out_valid0),
      .dataAvailable(data_available0), .bufferOverflow(buffer_overflow0),
      .banksFull(banks_full0), .overflowCount(overflow_count0)
   );

   multibank_buffer #(
      .DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .BANK_COUNT(COUNT), .HOLD_CYCLES(HOLD),
      .OVERFLOW_MODE(1)
   ) u_dut1 (
      .clock(clock), .reset(reset), .dataIn(data_in), .dataInValid(data_in_valid),
      .isReading(is_reading), .dataOut(data_out1), .dataOutValid(data_out_valid1),
      .dataAvailable(data_available1), .bufferOverflow(buffer_overflow1),
      .banksFull(banks_full1), .overflowCount(overflow_count1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: compare each returned word against the oldest outstanding expectation.
   always @(negedge clock) begin
      if (data_out_valid0) begin
         if (exp_q0.size() == 0) check_eq("spurious_valid0", {63'b0, data_out_valid0}, 64'd0);
         else check_eq("rd_data0", {48'b0, data_out0}, 64'(exp_q0.pop_front()));
      end
      if (data_out_valid1) begin
         if (exp_q1.size() == 0) check_eq("spurious_valid1", {63'b0, data_out_valid1}, 64'd0);
         else check_eq("rd_data1", {48'b0, data_out1}, 64'(exp_q1.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      data_in_valid = 1'b0;
      is_reading    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic write_seq(input int first, input int n, input bit gapped);
      for (int i = 0; i < n; i++) begin
         data_in       = DW'(first + i);
         data_in_valid = 1'b1;
         tick();
         if (gapped) begin
            data_in_valid = 1'b0;
            data_in       = 16'hDEAD;
            tick();
         end
      end
      data_in_valid = 1'b0;
   endtask

   task automatic read_seq(input int n, input int first0, input int first1);
      for (int i = 0; i < n; i++) begin
         is_reading = 1'b1;
         exp_q0.push_back(first0 + i);
         exp_q1.push_back(first1 + i);
         tick();
      end
      is_reading = 1'b0;
      tick();
      tick();
      check_eq("drain0", 64'(exp_q0.size()), 64'd0);
      check_eq("drain1", 64'(exp_q1.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_outs0"}, {data_out0, data_out_valid0, data_available0, buffer_overflow0,
                                 banks_full0, overflow_count0}, 64'd0);
      check_eq({tag, "_outs1"}, {data_out1, data_out_valid1, data_available1, buffer_overflow1,
                                 banks_full1, overflow_count1}, 64'd0);
   endtask

   initial begin
      int hi0, hi1;

      // Reset values while reset is held
      #2;
      check_all_zero("reset");
      do_reset();

      // Single bank write then burst read
      write_seq(0, 4, 1'b0);
      check_eq("t1_full0", 64'(banks_full0), 64'd1);
      check_eq("t1_avail0", 64'(data_available0), 64'd1);
      check_eq("t1_avail1", 64'(data_available1), 64'd1);
      read_seq(4, 0, 0);
      check_eq("t1_empty0", 64'(data_available0), 64'd0);
      check_eq("t1_bf0", 64'(banks_full0), 64'd0);

      // Gapped writes: two banks, no holes in stored data
      write_seq(10, 8, 1'b1);
      check_eq("t2_full0", 64'(banks_full0), 64'd2);
      read_seq(8, 10, 10);
      check_eq("t2_bf0", 64'(banks_full0), 64'd0);

      // Overflow: discard newest (dut0) vs discard oldest (dut1)
      do_reset();
      write_seq(0, 12, 1'b0);
      check_eq("t3_full0", 64'(banks_full0), 64'd3);
      check_eq("t3_full1", 64'(banks_full1), 64'd3);
      check_eq("t3_noovf0", 64'(buffer_overflow0), 64'd0);
      write_seq(12, 4, 1'b0);
      check_eq("t3_ovcnt0", 64'(overflow_count0), 64'd1);
      check_eq("t3_ovcnt1", 64'(overflow_count1), 64'd1);
      check_eq("t3_full_after0", 64'(banks_full0), 64'd3);
      check_eq("t3_full_after1", 64'(banks_full1), 64'd3);
      hi0 = 0;
      hi1 = 0;
      for (int i = 0; i < 20; i++) begin
         if (buffer_overflow0) hi0++;
         if (buffer_overflow1) hi1++;
         tick();
      end
      check_eq("t3_hold0", 64'(hi0), 64'(HOLD));
      check_eq("t3_hold1", 64'(hi1), 64'(HOLD));
      read_seq(12, 0, 4);
      check_eq("t3_bf0", 64'(banks_full0), 64'd0);
      check_eq("t3_bf1", 64'(banks_full1), 64'd0);

      // Overflow with a burst in progress: discard-oldest falls back
      do_reset();
      write_seq(0, 12, 1'b0);
      read_seq(1, 0, 0);
      write_seq(12, 4, 1'b0);
      check_eq("t5_ovcnt1", 64'(overflow_count1), 64'd1);
      check_eq("t5_full1", 64'(banks_full1), 64'd3);
      check_eq("t5_ovf1", 64'(buffer_overflow1), 64'd1);
      read_seq(11, 1, 1);

      // Bank completion coincides with final read of a bank at banksFull=3
      do_reset();
      write_seq(0, 12, 1'b0);
      read_seq(3, 0, 0);
      write_seq(12, 3, 1'b0);
      data_in       = 16'd15;
      data_in_valid = 1'b1;
      is_reading    = 1'b1;
      exp_q0.push_back(3);
      exp_q1.push_back(3);
      tick();
      data_in_valid = 1'b0;
      is_reading    = 1'b0;
      check_eq("t6_full0", 64'(banks_full0), 64'd3);
      check_eq("t6_full1", 64'(banks_full1), 64'd3);
      check_eq("t6_noovf0", 64'(buffer_overflow0), 64'd0);
      check_eq("t6_ovcnt1", 64'(overflow_count1), 64'd0);
      read_seq(12, 4, 4);

      // Asynchronous reset mid-burst
      do_reset();
      write_seq(0, 4, 1'b0);
      is_reading = 1'b1;
      exp_q0.push_back(0);
      exp_q1.push_back(0);
      tick();
      exp_q0.push_back(1);
      exp_q1.push_back(1);
      tick();
      @(negedge clock);
      #1;
      check_eq("t7_valid_pre0", 64'(data_out_valid0), 64'd1);
      reset = 1'b1;
      #1;
      check_all_zero("t7_async");
      #2;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t7_novalid0", 64'(data_out_valid0), 64'd0);
      end
      is_reading = 1'b0;
      check_eq("t7_q0", 64'(exp_q0.size()), 64'd0);
      write_seq(100, 3, 1'b0);
      check_eq("t7_notyet0", 64'(data_available0), 64'd0);
      write_seq(103, 1, 1'b0);
      check_eq("t7_avail0", 64'(data_available0), 64'd1);
      check_eq("t7_full1", 64'(banks_full1), 64'd1);
      read_seq(4, 100, 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
